// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared constants, types and helpers for the SRAM port arbiter.
//   ARB_ADDR_W / ARB_DATA_W  default word-address and data widths
//   ARB_STARVE_MAX           default starvation limit for the fetch port
//   ARB_CNT_W                width of the starvation counter (limit <= 15)
//   arb_src_e                which requester owns the SRAM this cycle
//   lane_bweb()              one byte enable -> eight active-low bit enables
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int ARB_ADDR_W     = 14;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_CNT_W      = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_I    = 2'd1,
    SRC_D    = 2'd2
  } arb_src_e;

  // The macro writes a bit when its BWEB bit is low, so an enabled byte
  // lane maps to eight zeros.
  function automatic logic [7:0] lane_bweb(input logic be);
    return {8{~be}};
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Counts consecutive cycles in which the fetch port asks but is refused.
// Once the count reaches STARVE_MAX, force_i tells the arbiter to let the
// fetch port win the next conflict.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   i_req     fetch request
//   i_gnt     fetch grant issued this cycle
//   force_i   fetch port must win if it is requesting
// -----------------------------------------------------------------------------
module arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic force_i
);

  localparam logic [ARB_CNT_W-1:0] MAX_C = ARB_CNT_W'(STARVE_MAX);

  logic [ARB_CNT_W-1:0] starve_cnt;

  // Any cycle where fetch is idle or served restarts the count; otherwise
  // count up and stick at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX_C) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_i = (starve_cnt == MAX_C);

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one single-port SRAM macro between the instruction-fetch port (I)
// and the load/store port (D). D has priority; a starvation guard lets I
// win one conflict after STARVE_MAX consecutive refusals. Reads return one
// cycle after the grant, tagged to the port that issued them.
//
// Optional feature (macro ARB_PERF_EN): 64-bit grant/conflict counters with
// a synchronous clear, exported as perf_cnt = {conflicts, d_grants, i_grants}.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_req/i_addr                fetch request and word address
//   i_gnt/i_rvalid/i_rdata      fetch grant, read-data valid, read data
//   d_req/d_we/d_addr/d_wdata   data request, byte write enables, address, data
//   d_gnt/d_rvalid/d_rdata      data grant, load-data valid, load data
//   sram_ceb/web/bweb/a/d       SRAM macro controls (active-low enables)
//   sram_q                      SRAM read data, valid the cycle after access
//   perf_clr, perf_cnt          performance counters (ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_ceb,
  output logic                sram_web,
  output logic [DATA_W-1:0]   sram_bweb,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
`ifdef ARB_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [191:0]        perf_cnt
`endif
);

  localparam int NBYTES = DATA_W / 8;

  arb_src_e            src;
  logic                force_i;
  logic                d_is_write;
  logic [DATA_W-1:0]   bweb_wr;
  logic                resp_i;
  logic                resp_d;

  assign d_is_write = |d_we;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_gnt   (i_gnt),
    .force_i (force_i)
  );

  // Grants are suppressed while reset is held so the macro is never touched
  // during reset, even if requesters keep their lines up.
  always_comb begin
    src = SRC_NONE;
    if (!rst) begin
      if (d_req && !(i_req && force_i)) begin
        src = SRC_D;
      end else if (i_req) begin
        src = SRC_I;
      end
    end
  end

  assign i_gnt = (src == SRC_I);
  assign d_gnt = (src == SRC_D);

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bweb
      assign bweb_wr[gi*8 +: 8] = lane_bweb(d_we[gi]);
    end
  endgenerate

  // Address and write data are forced to zero when idle so the macro pins
  // do not toggle with unrelated requester traffic.
  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (src)
      SRC_I: begin
        sram_ceb = 1'b0;
        sram_a   = i_addr;
      end
      SRC_D: begin
        sram_ceb = 1'b0;
        sram_a   = d_addr;
        if (d_is_write) begin
          sram_web  = 1'b0;
          sram_bweb = bweb_wr;
          sram_d    = d_wdata;
        end
      end
      default: begin
      end
    endcase
  end

  // Response tag: at most one grant per cycle, so at most one of these is
  // set; an asynchronous reset discards any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_i <= 1'b0;
      resp_d <= 1'b0;
    end else begin
      resp_i <= i_gnt;
      resp_d <= d_gnt & ~d_is_write;
    end
  end

  assign i_rvalid = resp_i;
  assign d_rvalid = resp_d;
  assign i_rdata  = resp_i ? sram_q : '0;
  assign d_rdata  = resp_d ? sram_q : '0;

`ifdef ARB_PERF_EN
  logic [63:0] perf_i_grants;
  logic [63:0] perf_d_grants;
  logic [63:0] perf_conflicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (perf_clr) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (i_gnt) perf_i_grants <= perf_i_grants + 64'd1;
      if (d_gnt) perf_d_grants <= perf_d_grants + 64'd1;
      if (i_req && d_req) perf_conflicts <= perf_conflicts + 64'd1;
    end
  end

  assign perf_cnt = {perf_conflicts, perf_d_grants, perf_i_grants};
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter with a behavioural SRAM macro, a
// shadow memory for expected read data and a response scoreboard.
// Build with +define+ARB_PERF_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [13:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        sram_ceb;
  logic        sram_web;
  logic [31:0] sram_bweb;
  logic [13:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;
`ifdef ARB_PERF_EN
  logic         perf_clr;
  logic [191:0] perf_cnt;
`endif

  int vectors;
  int miscompares;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] data;
  } resp_t;

  resp_t sbq[$];

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];

  sram_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_bweb (sram_bweb),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
`ifdef ARB_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .perf_cnt  (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port macro: bit-masked write, registered read.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) begin
        mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at posedge+1, check at the negedge, return at the
  // next posedge+1. Responses checked here belong to the previous cycle.
  task automatic cyc(input logic ir, input logic [13:0] ia, input logic dr,
                     input logic [3:0] dwe, input logic [13:0] da,
                     input logic [31:0] dwd, input logic eig, input logic edg);
    resp_t p;
    resp_t e;
    logic        wr;
    logic        eceb, eweb;
    logic [31:0] ebweb, ed;
    logic [13:0] ea;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    chk("i_gnt", 64'(i_gnt), 64'(eig));
    chk("d_gnt", 64'(d_gnt), 64'(edg));
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
      p = '{1'b0, 1'b0, 32'h0};
    end else begin
      p = sbq.pop_front();
    end
    chk("i_rvalid", 64'(i_rvalid), 64'(p.iv));
    chk("d_rvalid", 64'(d_rvalid), 64'(p.dv));
    chk("i_rdata", 64'(i_rdata), p.iv ? 64'(p.data) : 64'h0);
    chk("d_rdata", 64'(d_rdata), p.dv ? 64'(p.data) : 64'h0);
    wr    = edg && (dwe != 4'b0000);
    eceb  = !(eig || edg);
    eweb  = !wr;
    ebweb = 32'hFFFF_FFFF;
    ed    = 32'h0;
    ea    = eig ? ia : (edg ? da : 14'h0);
    if (wr) begin
      for (int b = 0; b < 4; b++) ebweb[b*8 +: 8] = dwe[b] ? 8'h00 : 8'hFF;
      ed = dwd;
    end
    chk("sram_ceb", 64'(sram_ceb), 64'(eceb));
    chk("sram_web", 64'(sram_web), 64'(eweb));
    chk("sram_bweb", 64'(sram_bweb), 64'(ebweb));
    chk("sram_a", 64'(sram_a), 64'(ea));
    if (wr || eceb) chk("sram_d", 64'(sram_d), 64'(ed));
    e = '{1'b0, 1'b0, 32'h0};
    if (eig) e = '{1'b1, 1'b0, ref_mem[ia]};
    else if (edg && !wr) e = '{1'b0, 1'b1, ref_mem[da]};
    sbq.push_back(e);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (dwe[b]) ref_mem[da][b*8 +: 8] = dwd[b*8 +: 8];
    end
    $display("cyc i_req=%0b d_req=%0b we=%h i_gnt=%0b d_gnt=%0b i_rv=%0b d_rv=%0b",
             ir, dr, dwe, i_gnt, d_gnt, i_rvalid, d_rvalid);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int a = 0; a < 16384; a++) begin
      mem[a] = 32'h0;
      ref_mem[a] = 32'h0;
    end
    mem[14'h0010] = 32'hDEADBEEF; ref_mem[14'h0010] = 32'hDEADBEEF;
    mem[14'h2000] = 32'hFFFFFFFF; ref_mem[14'h2000] = 32'hFFFFFFFF;
    mem[14'h3FFF] = 32'hA5A5_3FFF; ref_mem[14'h3FFF] = 32'hA5A5_3FFF;
    mem[14'h0000] = 32'h0BAD_0000; ref_mem[14'h0000] = 32'h0BAD_0000;
    mem[14'h0100] = 32'h1111_0100; ref_mem[14'h0100] = 32'h1111_0100;
    mem[14'h0200] = 32'h2222_0200; ref_mem[14'h0200] = 32'h2222_0200;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_gnt", 64'(i_gnt), 64'h0);
    chk("rst_d_gnt", 64'(d_gnt), 64'h0);
    chk("rst_i_rvalid", 64'(i_rvalid), 64'h0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'h0);
    chk("rst_sram_ceb", 64'(sram_ceb), 64'h1);
    chk("rst_sram_web", 64'(sram_web), 64'h1);
    chk("rst_sram_bweb", 64'(sram_bweb), 64'hFFFF_FFFF);
    chk("rst_starve_cnt", 64'(dut.u_starve.starve_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sbq.push_back('{1'b0, 1'b0, 32'h0});

    // Fetch alone, granted right after reset release
    cyc(1'b1, 14'h0010, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Partial-byte store, then read-after-write of the same word
    cyc(1'b0, 14'h0, 1'b1, 4'b0011, 14'h2000, 32'h12345678, 1'b0, 1'b1);
    cyc(1'b0, 14'h0, 1'b1, 4'b0000, 14'h2000, 32'h0, 1'b0, 1'b1);
    idle();
    chk("mem_2000", 64'(mem[14'h2000]), 64'hFFFF5678);

    // Continuous conflict: D four times, then I once, repeating
    for (int k = 0; k < 10; k++)
      cyc(1'b1, 14'h0100, 1'b1, 4'h0, 14'h0200, 32'h0, (k % 5) == 4, (k % 5) != 4);
    idle();

    // Alternating single-port reads at the address extremes
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) cyc(1'b0, 14'h0, 1'b1, 4'h0, 14'h3FFF, 32'h0, 1'b0, 1'b1);
      else            cyc(1'b1, 14'h0000, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0);
    end
    idle();

    // Reset in the middle of a granted D read
    cyc(1'b1, 14'h0100, 1'b1, 4'h0, 14'h0200, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 14'h0100, 1'b1, 4'h0, 14'h0200, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("midrst_d_gnt", 64'(d_gnt), 64'h1);
    rst = 1'b1;
    #1;
    chk("midrst_i_gnt", 64'(i_gnt), 64'h0);
    chk("midrst_d_gnt_off", 64'(d_gnt), 64'h0);
    chk("midrst_i_rvalid", 64'(i_rvalid), 64'h0);
    chk("midrst_d_rvalid", 64'(d_rvalid), 64'h0);
    chk("midrst_d_rdata", 64'(d_rdata), 64'h0);
    chk("midrst_sram_ceb", 64'(sram_ceb), 64'h1);
    chk("midrst_sram_bweb", 64'(sram_bweb), 64'hFFFF_FFFF);
    chk("midrst_starve_cnt", 64'(dut.u_starve.starve_cnt), 64'h0);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_d_rvalid", 64'(d_rvalid), 64'h0);
    chk("postrst_i_rvalid", 64'(i_rvalid), 64'h0);
    sbq.delete();
    sbq.push_back('{1'b0, 1'b0, 32'h0});
    // Counter restarted from zero: full four D grants before I
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 14'h0100, 1'b1, 4'h0, 14'h0200, 32'h0, k == 4, k != 4);
    idle();

`ifdef ARB_PERF_EN
    perf_clr = 1'b1;
    idle();
    perf_clr = 1'b0;
    for (int k = 0; k < 10; k++)
      cyc(1'b1, 14'h0100, 1'b1, 4'h0, 14'h0200, 32'h0, (k % 5) == 4, (k % 5) != 4);
    idle();
    chk("perf_i_grants", perf_cnt[63:0], 64'd2);
    chk("perf_d_grants", perf_cnt[127:64], 64'd8);
    chk("perf_conflicts", perf_cnt[191:128], 64'd10);
    perf_clr = 1'b1;
    idle();
    perf_clr = 1'b0;
    chk("perf_clr_i", perf_cnt[63:0], 64'd0);
    chk("perf_clr_d", perf_cnt[127:64], 64'd0);
    chk("perf_clr_c", perf_cnt[191:128], 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 32-bit SRAM macro (16384 words, active-low CEB/WEB/BWEB) between two requesters: instruction fetch (port I) and load/store (port D).
- Sits between the CPU core and the memory wrapper in top.
- Fixed priority to D, with a starvation guard for I.
- One-cycle read latency and a registered response tag.

Parameters:
- ADDR_W, 14, word-address width (16384 words).
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_MAX, 4, consecutive denied I-cycles before I is forced to win one cycle; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request, held until granted.
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request, held until granted.
- d_we  in  DATA_W/8  byte write enables, active-high; all-zero means read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid (reads only).
- d_rdata  out  DATA_W  load data.
- sram_ceb  out  1  chip enable, active-low.
- sram_web  out  1  write enable, active-low.
- sram_bweb  out  DATA_W  bit write enable, active-low.
- sram_a  out  ADDR_W  SRAM address.
- sram_d  out  DATA_W  SRAM write data.
- sram_q  in  DATA_W  SRAM read data, valid the cycle after the access.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Grant logic is combinational from requests and the starvation counter. At most one of i_gnt/d_gnt is high per cycle.
- Default priority: D wins when both request.
- Starvation counter `starve_cnt`:
  - Increments when i_req=1 and i_gnt=0.
  - Clears on i_gnt, or when i_req=0.
  - When starve_cnt==STARVE_MAX and both requesters are active, I wins and the counter clears.
  - The counter saturates at STARVE_MAX.
- SRAM drive in the grant cycle:
  - sram_ceb=0.
  - sram_a = the granted address.
  - Granted D write: sram_web=0, sram_bweb = bitwise NOT of each d_we bit replicated 8 times, sram_d = d_wdata.
  - Any read: sram_web=1, sram_bweb all ones.
  - No grant: sram_ceb=1, sram_web=1, sram_bweb all ones, sram_a and sram_d hold 0.
- Response register, updated every cycle:
  - resp_i <= i_gnt.
  - resp_d <= d_gnt & (d_we==0).
  - i_rvalid = resp_i and d_rvalid = resp_d; they are never high together.
  - i_rdata and d_rdata = sram_q while their rvalid is high, else 0.
  - Writes produce no rvalid.
- Throughput: back-to-back accesses every cycle. A grant in cycle N with a response in N+1 may coexist with a new grant in N+1.
- Read-after-write to the same address in consecutive cycles returns the new data; the SRAM handles the ordering and the block adds no bypass.
- Reset values: i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, rdata=0, sram_ceb=1, sram_web=1, sram_bweb all ones, starve_cnt=0.
- Reset asserted mid-access drops the pending response (no rvalid after release).
- First cycle after reset release: grants are allowed.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Adds 64-bit counters `perf_i_grants`, `perf_d_grants`, `perf_conflicts` (cycles with both requests).
  - Adds input perf_clr (sync clear) and output bus perf_cnt[191:0] = {conflicts, d_grants, i_grants}.
  - Counters reset to 0 on rst and wrap modulo 2^64.
- Undefined: the port and the counters are absent; arbitration is identical.

Decomposition:
- Package `sram_arb_pkg`:
  - ADDR_W/DATA_W default constants.
  - typedef enum {SRC_NONE, SRC_I, SRC_D} `arb_src_e`.
  - Function for byte-enable to active-low BWEB expansion.
- One sub-module `arb_starve_cnt` holds the saturating counter and the force-I flag.

Test Plan:
- i_req only, i_addr=0x0010, SRAM preloaded 0xDEADBEEF → i_gnt same cycle, i_rvalid next cycle, i_rdata=0xDEADBEEF, d_* idle.
- d_req write, d_we=4'b0011, d_addr=0x2000, d_wdata=0x12345678 over 0xFFFFFFFF → sram_bweb=0xFFFF0000, word becomes 0xFFFF5678, no d_rvalid.
- i_req and d_req held continuously → D granted 4 cycles, I granted on the 5th, pattern repeats; never two grants in one cycle.
- Alternating D-read/I-read every cycle at addresses 0x3FFF/0x0000 → one grant per cycle, responses tagged to the correct port with 1-cycle latency, no bubbles.
- Grant D-read at cycle N, assert rst at N+0.5 → d_rvalid stays 0, all outputs at reset values, counter=0.
- ARB_PERF_EN, 10 conflict cycles → perf_conflicts=10, d_grants=8, i_grants=2; perf_clr → all 0.
